// File: rtl/mealy_state_seq_if.sv
// mealy_state_seq_if: controller-side bundle (clear/in_valid/in in; state/step/steps/in_d/timeout out), master=driver, slave=mealy_state_seq
interface mealy_state_seq_if #(
  parameter int CNT_W = 8
);
  logic clear;
  logic in_valid;
  logic in;
  logic [1:0] state;
  logic step;
  logic [CNT_W-1:0] steps;
  logic in_d;
  logic timeout;
  modport master (output clear, in_valid, in, input state, step, steps, in_d, timeout);
  modport slave (input clear, in_valid, in, output state, step, steps, in_d, timeout);
endinterface

// File: rtl/mealy_state_seq.sv
// mealy_state_seq: A/B/C/D state register + next-state, step strobe, saturating steps count, in_d flag; ports clk, reset, bus (mealy_state_seq_if.slave); `DWELL_TIMEOUT_EN adds forced D->A exit after DWELL_MAX cycles
module mealy_state_seq #(
  parameter int CNT_W = 8,
  parameter int DWELL_MAX = 8
) (
  input logic clk,
  input logic reset,
  mealy_state_seq_if.slave bus
);
  typedef enum logic [1:0] {A = 2'b00, B = 2'b01, C = 2'b10, D = 2'b11} state_t;
  state_t state_q, state_d, nxt;
  logic acc, exit_d;
  logic step_q, step_d;
  logic timeout_q, timeout_d;
  logic [CNT_W-1:0] steps_q, steps_d;
`ifdef DWELL_TIMEOUT_EN
  logic [7:0] dwell_q, dwell_d;
  always_comb begin
    exit_d = state_q == D && dwell_q == 8'(DWELL_MAX - 1);
    dwell_d = (bus.clear || state_q != D) ? 8'd0 : dwell_q + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) dwell_q <= 8'd0;
    else dwell_q <= dwell_d;
  end
`else
  logic [31:0] unused_dwell_max;
  assign unused_dwell_max = 32'(DWELL_MAX);
  always_comb exit_d = 1'b0;
`endif
  always_comb begin
    nxt = state_q == A ? (bus.in ? C : B) :
          state_q == B ? (bus.in ? A : D) :
          state_q == C ? (bus.in ? D : B) : D;
    acc = bus.in_valid && !bus.clear && !exit_d;
    state_d = (bus.clear || exit_d) ? A : acc ? nxt : state_q;
    step_d = acc;
    steps_d = bus.clear ? '0 : (acc && steps_q != '1) ? steps_q + 1'b1 : steps_q;
    timeout_d = exit_d && !bus.clear;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= A;
      step_q <= 1'b0;
      steps_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      steps_q <= steps_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.state = state_q;
  assign bus.step = step_q;
  assign bus.steps = steps_q;
  assign bus.in_d = state_q == D;
  assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_mealy_state_seq.sv
// tb_mealy_state_seq: table-driven and directed checks of mealy_state_seq with CNT_W=3, DWELL_MAX=4
module tb_mealy_state_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  mealy_state_seq_if #(.CNT_W(3)) bus();
  mealy_state_seq #(.CNT_W(3), .DWELL_MAX(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic r, c, v, i;
    logic [1:0] st;
    logic stp;
    logic [2:0] cnt;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic r, c, v, i, input logic [1:0] st, input logic stp, input logic [2:0] cnt);
    vec_t e;
    e.r = r; e.c = c; e.v = v; e.i = i; e.st = st; e.stp = stp; e.cnt = cnt;
    tbl.push_back(e);
  endtask
  task automatic cyc(input logic r, c, v, i, input logic [1:0] st, input logic stp,
                     input logic [2:0] cnt, input logic to, input string nm);
    @(negedge clk);
    reset = r; bus.clear = c; bus.in_valid = v; bus.in = i;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.state, bus.step, bus.steps, bus.in_d, bus.timeout} !== {st, stp, cnt, &st, to}) begin
      errors++;
      $display("FAIL %s: got state=%b step=%b steps=%0d in_d=%b timeout=%b, want state=%b step=%b steps=%0d in_d=%b timeout=%b",
               nm, bus.state, bus.step, bus.steps, bus.in_d, bus.timeout, st, stp, cnt, &st, to);
    end
  endtask
  initial begin
    bus.clear = 1'b0; bus.in_valid = 1'b1; bus.in = 1'b1;
    add(1, 0, 1, 1, 2'd0, 0, 3'd0);
    add(1, 0, 1, 1, 2'd0, 0, 3'd0);
    add(0, 0, 0, 0, 2'd0, 0, 3'd0);
    add(0, 0, 1, 0, 2'd1, 1, 3'd1);
    add(0, 0, 1, 1, 2'd0, 1, 3'd2);
    add(0, 0, 1, 1, 2'd2, 1, 3'd3);
    add(0, 0, 1, 0, 2'd1, 1, 3'd4);
    add(0, 0, 1, 1, 2'd0, 1, 3'd5);
    add(0, 0, 0, 1, 2'd0, 0, 3'd5);
    add(0, 0, 1, 1, 2'd2, 1, 3'd6);
    add(0, 0, 0, 0, 2'd2, 0, 3'd6);
    add(0, 0, 0, 1, 2'd2, 0, 3'd6);
    add(0, 1, 1, 1, 2'd0, 0, 3'd0);
    add(0, 0, 1, 1, 2'd2, 1, 3'd1);
    add(0, 0, 1, 0, 2'd1, 1, 3'd2);
    add(0, 0, 1, 1, 2'd0, 1, 3'd3);
    add(0, 0, 1, 1, 2'd2, 1, 3'd4);
    add(0, 0, 1, 0, 2'd1, 1, 3'd5);
    add(0, 0, 1, 1, 2'd0, 1, 3'd6);
    add(0, 0, 1, 1, 2'd2, 1, 3'd7);
    add(0, 0, 1, 0, 2'd1, 1, 3'd7);
    add(0, 0, 1, 1, 2'd0, 1, 3'd7);
    add(0, 0, 1, 1, 2'd2, 1, 3'd7);
    add(0, 0, 0, 0, 2'd2, 0, 3'd7);
    add(1, 1, 1, 0, 2'd0, 0, 3'd0);
    add(0, 0, 1, 0, 2'd1, 1, 3'd1);
    add(0, 1, 0, 0, 2'd0, 0, 3'd0);
    foreach (tbl[k])
      cyc(tbl[k].r, tbl[k].c, tbl[k].v, tbl[k].i, tbl[k].st, tbl[k].stp, tbl[k].cnt, 1'b0, $sformatf("vec%0d", k));
    cyc(0, 0, 1, 0, 2'd1, 1, 3'd1, 1'b0, "to_b");
    cyc(0, 0, 1, 0, 2'd3, 1, 3'd2, 1'b0, "to_d");
`ifdef DWELL_TIMEOUT_EN
    for (int k = 0; k < 3; k++)
      cyc(0, 0, 1, 1'(k), 2'd3, 1, 3'(3 + k), 1'b0, $sformatf("dwell%0d", k));
    cyc(0, 0, 1, 1, 2'd0, 0, 3'd5, 1'b1, "timeout_exit");
    cyc(0, 0, 0, 0, 2'd0, 0, 3'd5, 1'b0, "timeout_pulse_end");
    cyc(0, 1, 0, 0, 2'd0, 0, 3'd0, 1'b0, "clear2");
    cyc(0, 0, 1, 0, 2'd1, 1, 3'd1, 1'b0, "to_b2");
    cyc(0, 0, 1, 0, 2'd3, 1, 3'd2, 1'b0, "to_d2");
    for (int k = 0; k < 3; k++)
      cyc(0, 0, 1, 1'(k), 2'd3, 1, 3'(3 + k), 1'b0, $sformatf("dwell_b%0d", k));
    cyc(0, 1, 1, 1, 2'd0, 0, 3'd0, 1'b0, "clear_on_exit");
`else
    for (int k = 0; k < 20; k++)
      cyc(0, 0, 1, 1'(k % 3 == 1), 2'd3, 1, (k + 3 > 7) ? 3'd7 : 3'(k + 3), 1'b0, $sformatf("absorb%0d", k));
    cyc(0, 0, 0, 1, 2'd3, 0, 3'd7, 1'b0, "absorb_idle");
    cyc(0, 1, 1, 1, 2'd0, 0, 3'd0, 1'b0, "clear_from_d");
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
